// File: rtl/pe_array_driver.sv
// Job sequencer that streams target characters into a PE array and tracks the best score.
// Optional DRIVER_MAXTRACK_EN adds best_pos tracking; otherwise best_pos is tied to zero.
`timescale 1ns/1ps
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module pe_array_driver #(
    parameter int PE_NUM  = 2,
    parameter int LEN_BIT = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [2*PE_NUM-1:0]          s_in,
    input  logic [LEN_BIT-1:0]           t_len,
    input  logic                         t_valid,
    input  logic [1:0]                   t_data,
    output logic                         t_ready,
    output logic [PE_NUM-1:0]            enable,
    output logic                         newLine,
    output logic [2*PE_NUM-1:0]          s_out,
    output logic [1:0]                   t_out,
    output logic signed [`V_E_F_Bit-1:0] v_out,
    output logic signed [`V_E_F_Bit-1:0] v_alpha_out,
    output logic signed [`V_E_F_Bit-1:0] f_out,
    input  logic signed [`V_E_F_Bit-1:0] result,
    output logic                         busy,
    output logic                         done,
    output logic signed [`V_E_F_Bit-1:0] score,
    output logic [LEN_BIT-1:0]           best_pos
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | issuing target characters, enable follows each issue
    // DRAIN | flushing the last columns through the array
    // DONE  | score latched, done pulse
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int VW    = `V_E_F_Bit;
    localparam int ADV_W = LEN_BIT + 1;

    state_t                state_q, state_d;
    logic [2*PE_NUM-1:0]   s_q, s_d;
    logic [LEN_BIT-1:0]    len_q, len_d;
    logic [LEN_BIT-1:0]    cnt_q, cnt_d;
    logic [PE_NUM-1:0]     sr_q, sr_d;
    logic [PE_NUM-1:0]     en_q, en_d;
    logic                  nl_q, nl_d;
    logic [1:0]            tout_q, tout_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic signed [VW-1:0]  max_q, max_d;
    logic signed [VW-1:0]  score_q, score_d;
    logic                  issue;
`ifdef DRIVER_MAXTRACK_EN
    logic [ADV_W-1:0]      adv_q, adv_d;
    logic [LEN_BIT-1:0]    mpos_q, mpos_d;
    logic [LEN_BIT-1:0]    bpos_q, bpos_d;
`endif

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        en_d    = '0;
        nl_d    = 1'b0;
        tout_d  = tout_q;
        done_d  = 1'b0;
        score_d = score_q;
        max_d   = max_q;
        issue   = (state_q == S_RUN) && t_valid && ready_q;

        // ties keep the earlier max so the first column reaching it wins
        if ((en_q != '0) && (result > max_q)) begin
            max_d = result;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_d   = s_in;
                    len_d = t_len;
                    cnt_d = '0;
                    sr_d  = '0;
                    max_d = '0;
                    if (t_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        score_d = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    tout_d = t_data;
                    nl_d   = (cnt_q == '0);
                    sr_d   = (sr_q << 1) | PE_NUM'(1);
                    en_d   = sr_d;
                    cnt_d  = cnt_q + LEN_BIT'(1);
                    if (cnt_d == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                sr_d = sr_q << 1;
                en_d = sr_d;
                if (sr_d == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    score_d = max_d;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_RUN) && (cnt_d < len_d);
        busy_d  = (state_d != S_IDLE);
    end

`ifdef DRIVER_MAXTRACK_EN
    // adv counts array steps; the last PE sees target index adv - (PE_NUM-1)
    always_comb begin
        adv_d  = adv_q;
        mpos_d = mpos_q;
        bpos_d = bpos_q;
        if (en_q != '0) begin
            adv_d = adv_q + ADV_W'(1);
            if (result > max_q) begin
                mpos_d = (adv_q >= ADV_W'(PE_NUM - 1)) ?
                         LEN_BIT'(adv_q - ADV_W'(PE_NUM - 1)) : '0;
            end
        end
        if ((state_q == S_IDLE) && start) begin
            adv_d  = '0;
            mpos_d = '0;
        end
        if (done_d) begin
            bpos_d = mpos_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            en_q    <= '0;
            nl_q    <= 1'b0;
            tout_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            max_q   <= '0;
            score_q <= '0;
`ifdef DRIVER_MAXTRACK_EN
            adv_q   <= '0;
            mpos_q  <= '0;
            bpos_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            en_q    <= en_d;
            nl_q    <= nl_d;
            tout_q  <= tout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            max_q   <= max_d;
            score_q <= score_d;
`ifdef DRIVER_MAXTRACK_EN
            adv_q   <= adv_d;
            mpos_q  <= mpos_d;
            bpos_q  <= bpos_d;
`endif
        end
    end

    assign t_ready     = ready_q;
    assign enable      = en_q;
    assign newLine     = nl_q;
    assign s_out       = s_q;
    assign t_out       = tout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign score       = score_q;
    assign v_out       = '0;
    assign v_alpha_out = '0;
    assign f_out       = '0;
`ifdef DRIVER_MAXTRACK_EN
    assign best_pos    = bpos_q;
`else
    assign best_pos    = '0;
`endif

endmodule

// File: tb/tb_pe_array_driver.sv
// Randomized bench for pe_array_driver: a Smith-Waterman affine-gap array model feeds result,
// and a job-level timeline model predicts every output each cycle.
`timescale 1ns/1ps
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module tb_pe_array_driver;
    localparam int PE   = 2;
    localparam int LB   = 10;
    localparam int W    = `V_E_F_Bit;
    localparam int MAXL = 40;
    localparam int NEG  = -1000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [2*PE-1:0]     s_in = '0;
    logic [LB-1:0]       t_len = '0;
    logic                t_valid = 1'b0;
    logic [1:0]          t_data = '0;
    logic signed [W-1:0] result = '0;
    logic                t_ready;
    logic [PE-1:0]       enable;
    logic                newLine;
    logic [2*PE-1:0]     s_out;
    logic [1:0]          t_out;
    logic signed [W-1:0] v_out, v_alpha_out, f_out, score;
    logic                busy, done;
    logic [LB-1:0]       best_pos;

    pe_array_driver #(.PE_NUM(PE), .LEN_BIT(LB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(s_in), .t_len(t_len),
        .t_valid(t_valid), .t_data(t_data), .t_ready(t_ready), .enable(enable),
        .newLine(newLine), .s_out(s_out), .t_out(t_out), .v_out(v_out),
        .v_alpha_out(v_alpha_out), .f_out(f_out), .result(result), .busy(busy),
        .done(done), .score(score), .best_pos(best_pos)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int exp_en, exp_nl, exp_tout, exp_sout, exp_ready, exp_busy, exp_done, exp_score, exp_bp;
    bit chk_en = 1'b0;
    int g_score = 0, g_bp = 0, g_tout = 0, g_sout = 0;

    int tg[MAXL];
    int hm[PE][MAXL];

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("enable",   int'(enable),   exp_en);
            chk("newLine",  int'(newLine),  exp_nl);
            chk("t_out",    int'(t_out),    exp_tout);
            chk("s_out",    int'(s_out),    exp_sout);
            chk("t_ready",  int'(t_ready),  exp_ready);
            chk("busy",     int'(busy),     exp_busy);
            chk("done",     int'(done),     exp_done);
            chk("score",    int'(score),    exp_score);
            chk("best_pos", int'(best_pos), exp_bp);
            chk("boundary", int'(v_out) | int'(v_alpha_out) | int'(f_out), 0);
        end
    end

    function automatic int ones(input int x);
        return (1 << x) - 1;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Gotoh local alignment: match 2, mismatch -1, gap open 2, gap extend 1
    task automatic sw_fill(input logic [2*PE-1:0] s, input int len);
        int e[PE][MAXL];
        int f[PE][MAXL];
        for (int i = 0; i < PE; i++) begin
            for (int j = 0; j < len; j++) begin
                int diag, up, left, sc, h;
                diag = (i > 0 && j > 0) ? hm[i-1][j-1] : 0;
                up   = (i > 0) ? hm[i-1][j] : 0;
                left = (j > 0) ? hm[i][j-1] : 0;
                e[i][j] = imax(left - 2, ((j > 0) ? e[i][j-1] : NEG) - 1);
                f[i][j] = imax(up - 2, ((i > 0) ? f[i-1][j] : NEG) - 1);
                sc = (int'(s[2*i +: 2]) == tg[j]) ? 2 : -1;
                h = imax(0, diag + sc);
                h = imax(h, imax(e[i][j], f[i][j]));
                hm[i][j] = h;
            end
        end
    endtask

    task automatic load_t(input int c0, input int c1, input int c2);
        for (int i = 0; i < MAXL; i++) tg[i] = $urandom_range(3);
        tg[0] = c0; tg[1] = c1; tg[2] = c2;
    endtask

    // noise: 0 no start during job, 1 random, 2 every non-idle cycle
    task automatic run_job(input logic [2*PE-1:0] s, input int len, input int vprob,
                           input bit stall3, input int noise, input bit abort,
                           output int done_off, output int last_iss);
        int issued, a, last, first, done_n, stall_left, job_score, job_bp, run, r;
        bit finished, idle_tail, prev_issue;
        sw_fill(s, len);
        run = 0; job_bp = 0;
        for (int k = 0; k < len + PE - 1; k++) begin
            int m;
            m = 0;
            for (int p = 0; p < PE; p++)
                if (k - p >= 0 && k - p < len) m = imax(m, hm[p][k-p]);
            if (m > run) begin
                run = m;
                job_bp = (k - (PE - 1) < 0) ? 0 : k - (PE - 1);
            end
        end
        job_score = run;
`ifndef DRIVER_MAXTRACK_EN
        job_bp = 0;
`endif
        issued = 0; a = 0; last = -1; first = -1; stall_left = 3;
        done_n = (len == 0) ? 1 : -1;
        finished = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            idle_tail = (done_n >= 0) && (n > done_n);
            if (n == 0 || idle_tail) begin
                exp_busy = 0; exp_ready = 0; exp_en = 0; exp_nl = 0; exp_done = 0;
            end else begin
                g_sout = int'(s);
                prev_issue = (last == n - 1);
                if (len == 0)             exp_en = 0;
                else if (prev_issue)      exp_en = ones((issued < PE) ? issued : PE);
                else if (issued < len)    exp_en = 0;
                else                      exp_en = (ones((len < PE) ? len : PE) << (n - 1 - last)) & ones(PE);
                exp_ready = (len > 0 && issued < len) ? 1 : 0;
                exp_nl = (prev_issue && first == n - 1) ? 1 : 0;
                if (prev_issue) g_tout = tg[issued-1];
                if (len > 0 && issued == len && done_n < 0) done_n = last + PE + 1;
                exp_done = (n == done_n) ? 1 : 0;
                exp_busy = 1;
                if (n == done_n) begin
                    g_score = job_score;
                    g_bp = job_bp;
                end
            end
            exp_tout = g_tout; exp_sout = g_sout; exp_score = g_score; exp_bp = g_bp;
            chk_en = 1'b1;

            if (n == 0) begin
                start = 1'b1; s_in = s; t_len = LB'(len);
                t_valid = 1'($urandom_range(1)); t_data = 2'($urandom_range(3));
            end else begin
                start = 1'b0;
                if (!idle_tail && (noise == 2 || (noise == 1 && $urandom_range(1) == 1))) begin
                    start = 1'b1;
                    s_in = (2*PE)'($urandom);
                    t_len = LB'($urandom_range(1, 20));
                end
                t_valid = ($urandom_range(99) < vprob);
                if (stall3 && issued == 1 && stall_left > 0) begin
                    t_valid = 1'b0;
                    stall_left--;
                end
                t_data = t_valid ? 2'(tg[issued]) : 2'($urandom_range(3));
                if (exp_ready == 1 && t_valid) begin
                    if (first < 0) first = n;
                    last = n;
                    issued++;
                end
            end

            if (exp_en != 0) begin
                r = 0;
                for (int p = 0; p < PE; p++)
                    if (exp_en[p]) r = imax(r, hm[p][a-p]);
                a++;
            end else begin
                r = $urandom_range(60) - 30;
            end
            result = W'(r);

            if (abort && len > 0 && issued == len && n == last + 1) begin
                finished = 1'b1;
                break;
            end
            if (idle_tail) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) chk("job_timeout", 0, 1);
        done_off = done_n;
        last_iss = last;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_enable"},   int'(enable),   0);
        chk({tag, "_newLine"},  int'(newLine),  0);
        chk({tag, "_t_out"},    int'(t_out),    0);
        chk({tag, "_s_out"},    int'(s_out),    0);
        chk({tag, "_t_ready"},  int'(t_ready),  0);
        chk({tag, "_busy"},     int'(busy),     0);
        chk({tag, "_done"},     int'(done),     0);
        chk({tag, "_score"},    int'(score),    0);
        chk({tag, "_best_pos"}, int'(best_pos), 0);
    endtask

    initial begin
        int doff, lst, d_basic;
        rst_n = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        load_t(0, 1, 0);
        run_job(4'b0100, 2, 100, 1'b0, 0, 1'b0, doff, lst);
        chk("basic_done_latency", doff - lst, 3);
        chk("basic_score", int'(score), 4);
        d_basic = doff;

        run_job(4'b0100, 2, 100, 1'b1, 0, 1'b0, doff, lst);
        chk("stall_done_delay", doff - d_basic, 3);
        chk("stall_score", int'(score), 4);

        run_job(4'b0100, 0, 100, 1'b0, 0, 1'b0, doff, lst);
        chk("zero_len_done_off", doff, 1);
        chk("zero_len_score", int'(score), 0);

        run_job(4'b0100, 2, 100, 1'b0, 2, 1'b0, doff, lst);
        chk("start_ignored_score", int'(score), 4);

        run_job(4'b0100, 2, 100, 1'b0, 0, 1'b1, doff, lst);
        @(negedge clk); #1;
        chk_en = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        g_score = 0; g_bp = 0; g_tout = 0; g_sout = 0;

        load_t(2, 3, 0);
        run_job(4'b0100, 2, 100, 1'b0, 0, 1'b0, doff, lst);
        chk("gt_score", int'(score), 0);

        load_t(2, 0, 1);
        run_job(4'b0100, 3, 100, 1'b0, 0, 1'b0, doff, lst);
        chk("gac_score", int'(score), 4);
`ifdef DRIVER_MAXTRACK_EN
        chk("gac_best_pos", int'(best_pos), 2);
`else
        chk("gac_best_pos", int'(best_pos), 0);
`endif

        for (int j = 0; j < 30; j++) begin
            load_t($urandom_range(3), $urandom_range(3), $urandom_range(3));
            run_job((2*PE)'($urandom), $urandom_range(12), $urandom_range(30, 100),
                    1'b0, 1, 1'b0, doff, lst);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_array_driver.md
PE_ARRAY_DRIVER -- requirements
Module: pe_array_driver

Interface
REQ-001 SHALL have parameter PE_NUM, default 2: number of PEs in the driven array (one enable bit and one 2-bit query character each).
REQ-002 SHALL have parameter LEN_BIT, default 10: width of the target-length field.
REQ-003 SHALL size all score, V, F and alpha/beta buses at `V_E_F_Bit, signed two's complement.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-007 s_in  input  2*PE_NUM  query segment; PE k character at [2k+1:2k]; captured on accepted start.
REQ-008 t_len  input  LEN_BIT  target length in characters; captured on accepted start.
REQ-009 t_valid / t_data / t_ready  input 1 / input 2 / output 1  target character stream, valid/ready handshake.
REQ-010 enable  output  PE_NUM  per-PE enable; low freezes that PE.
REQ-011 newLine, s_out[2*PE_NUM], t_out[2]  outputs  start-of-row marker, held query, current target character.
REQ-012 v_out, v_alpha_out, f_out  outputs  `V_E_F_Bit  boundary values into PE 1.
REQ-013 result  input  `V_E_F_Bit  array's combined max output, sampled each cycle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at job end.
REQ-016 score  output  `V_E_F_Bit  best score; held from done until the next accepted start.
REQ-017 best_pos  output  LEN_BIT  see Configuration.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 SHALL move IDLE->RUN on start=1 with t_len>0, and IDLE->DONE on start=1 with t_len=0 (score=0).
REQ-020 SHALL assert t_ready only in RUN while the issued count is below t_len; a character issues on t_valid&&t_ready.
REQ-021 SHALL present issued t_data on t_out the following cycle and assert newLine in that same cycle for the first character only.
REQ-022 SHALL keep an enable shift register (bit 0 = PE 1); on an issue cycle it shifts in 1, in DRAIN it shifts in 0.
REQ-023 SHALL drive enable to all zero and hold the shift register and t_out when in RUN with no issue (stall).
REQ-024 SHALL move RUN->DRAIN in the cycle the t_len-th character issues, and DRAIN->DONE when the shift register is all zero.
REQ-025 SHALL drive v_out=0, v_alpha_out=0, f_out=0 constantly (local-alignment zero boundary).
REQ-026 SHALL, in any cycle with enable!=0, update running max with signed compare: max = (result>max) ? result : max; ties keep the old value.
REQ-027 SHALL clear the running max to 0 on accepted start.
REQ-028 SHALL, in DONE, copy max to score, pulse done for one cycle, then return to IDLE.
REQ-029 SHALL ignore start in RUN, DRAIN and DONE.
REQ-030 SHALL make drain length exactly PE_NUM cycles after the last issue with no stalls; done rises PE_NUM+1 cycles after the last issue.

Reset
REQ-031 SHALL, on rst_n low and regardless of state (including mid-job), enter IDLE and zero enable, newLine, t_out, s_out, t_ready, busy, done, score, best_pos, max and counters.
REQ-032 SHALL make the reset deassertion cycle behave as IDLE, with no spurious done.

Configuration
REQ-033 SHALL, with DRIVER_MAXTRACK_EN defined, record in best_pos the 0-based target index whose PE_NUM-th (last) column produced the final max, latched with score.
REQ-034 SHALL, without DRIVER_MAXTRACK_EN, tie best_pos to 0 and include no position-tracking registers.

Verification
Default settings for all scenarios: PE_NUM=2; encoding A=00 C=01 G=10 T=11; match=2, mismatch=-1, alpha=2, beta=1.
REQ-035 Basic job: s_in=4'b0100 ("AC"), t="AC", t_len=2, t_valid constant -> score=4, done exactly 3 cycles after the 2nd issue, newLine on the first t_out only.
REQ-036 Stall: same job, t_valid low for 3 cycles between characters -> enable=00 during the stall, score=4, done delayed by exactly 3 cycles.
REQ-037 Zero length: start with t_len=0 -> done the next cycle, score=0, no enable activity.
REQ-038 Mid-job reset: rst_n low 1 cycle during DRAIN -> all outputs 0, IDLE; a subsequent job on t="GT" against "AC" -> score=0.
REQ-039 Start ignored: start reasserted during RUN -> no capture, job result unchanged, busy stays 1.
REQ-040 MAXTRACK: with DRIVER_MAXTRACK_EN, t="GAC" against "AC" -> score=4, best_pos=2; without it, best_pos=0.
